// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine and its step datapath.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  localparam int MODE_SUB = 0;
  localparam int MODE_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// Combinational single-step GCD datapath: subtractive Euclid or binary (Stein).
// Also reports whether the current operand pair is already terminal and its result.
module gcd_step #(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             terminal,
  output logic [WIDTH-1:0] term_result
);

  always_comb begin
    x_nxt    = x;
    y_nxt    = y;
    k_nxt    = k;
    terminal = (x == y) || (x == '0) || (y == '0);
    // x|y covers both x==y (gives x) and the single-zero case (gives the other).
    term_result = (x | y) << k;
    if (mode) begin
      if (!x[0] && !y[0]) begin
        x_nxt = x >> 1;
        y_nxt = y >> 1;
        k_nxt = k + KW'(1);
      end else if (!x[0]) begin
        x_nxt = x >> 1;
      end else if (!y[0]) begin
        y_nxt = y >> 1;
      end else if (x > y) begin
        x_nxt = x - y;
      end else begin
        y_nxt = y - x;
      end
    end else begin
      if (x > y) x_nxt = x - y;
      else       y_nxt = y - x;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: valid/ready operand intake, iterative step loop with timeout, held result.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds data until then.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MODE     = 0,
  parameter int MAX_ITER = 1024,
  localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iters,
  output logic             err,
  output gcd_state_t       state_dbg
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  gcd_state_t       state;
  logic [WIDTH-1:0] x, y;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] x_nxt, y_nxt, term_result;
  logic [KW-1:0]    k_nxt;
  logic             terminal;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .mode        (MODE == MODE_BIN),
    .x           (x),
    .y           (y),
    .k           (k),
    .x_nxt       (x_nxt),
    .y_nxt       (y_nxt),
    .k_nxt       (k_nxt),
    .terminal    (terminal),
    .term_result (term_result)
  );

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      iters     <= '0;
      err       <= 1'b0;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= a_in;
            y        <= b_in;
            k        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // A naturally finished pair wins over the budget check on the same cycle.
          if (terminal) begin
            result    <= term_result;
            err       <= 1'b0;
            iters     <= cnt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == MAX_CNT) begin
            result    <= '0;
            err       <= 1'b1;
            iters     <= cnt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x   <= x_nxt;
            y   <= y_nxt;
            k   <= k_nxt;
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three configurations (Euclid, Stein, Euclid with a tiny budget)
// driven with directed and random operand pairs, checked by a queue-based scoreboard.
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int W = 30;  // {tag[1:0], result[15:0], iters[10:0], err}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       iv, ir, ov, er, ordy;
  logic [2:0][15:0] av, bv, res;
  logic [10:0]      it0, it1;
  logic [3:0]       it2;
  gcd_state_t       st0, st1, st2;

  gcd_engine #(.WIDTH(16), .MODE(0), .MAX_ITER(1024)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a_in(av[0]), .b_in(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .iters(it0), .err(er[0]),
    .state_dbg(st0));
  gcd_engine #(.WIDTH(16), .MODE(1), .MAX_ITER(1024)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a_in(av[1]), .b_in(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .iters(it1), .err(er[1]),
    .state_dbg(st1));
  gcd_engine #(.WIDTH(16), .MODE(0), .MAX_ITER(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a_in(av[2]), .b_in(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]), .iters(it2), .err(er[2]),
    .state_dbg(st2));

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc[3];
  logic [2:0] ov_q = '0;
  logic bp_en = 1'b0;

  always @(posedge clk) cyc++;

  function automatic int get_it(input int i);
    case (i)
      0:       return int'(it0);
      1:       return int'(it1);
      default: return int'(it2);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: gcd by division-remainder; step counts from the algorithm's rules.
  function automatic logic [W-1:0] model(input int idx, input int a, input int b);
    int x, y, t, q, r, g, n, max_it;
    logic e;
    max_it = (idx == 2) ? 8 : 1024;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    g = x;
    n = 0;
    if (a != 0 && b != 0) begin
      if (idx == 1) begin
        x = a; y = b;
        while (x != y) begin
          if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
          else if (x % 2 == 0) x = x / 2;
          else if (y % 2 == 0) y = y / 2;
          else if (x > y) x = x - y;
          else y = y - x;
          n++;
        end
      end else begin
        // Subtractive Euclid does q subtractions per quotient, one fewer on the last.
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        forever begin
          q = x / y; r = x % y;
          if (r == 0) begin n += q - 1; break; end
          n += q; x = y; y = r;
        end
      end
    end
    e = 1'b0;
    if (n > max_it) begin n = max_it; g = 0; e = 1'b1; end
    return {2'(idx), 16'(g), 11'(n), e};
  endfunction

  // Monitor: latency on rising out_valid, field compare on each output handshake.
  always @(negedge clk) begin
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      if (iv[i] && ir[i]) acc_cyc[i] = cyc + 1;
      if (ov[i] && !ov_q[i]) begin
        if (exp_q.size() == 0 || int'(exp_q[0][29:28]) != i) begin
          checks++; errors++;
          $display("FAIL unexpected_output: dut %0d result %0d with nothing pending", i, res[i]);
        end else begin
          chk($sformatf("latency[%0d]", i), cyc - acc_cyc[i], int'(exp_q[0][11:1]) + 1);
        end
      end
      if (ov[i] && ordy[i] && exp_q.size() > 0 && int'(exp_q[0][29:28]) == i) begin
        e = exp_q.pop_front();
        chk($sformatf("result[%0d]", i), int'(res[i]), int'(e[27:12]));
        chk($sformatf("iters[%0d]", i), get_it(i), int'(e[11:1]));
        chk($sformatf("err[%0d]", i), int'(er[i]), int'(e[0]));
      end
      ov_q[i] = ov[i];
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) for (int i = 0; i < 3; i++) ordy[i] = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    iv[idx] = 1'b1; av[idx] = a; bv[idx] = b;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ir[idx]) begin
        exp_q.push_back(model(idx, int'(a), int'(b)));
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    iv[idx] = 1'b0;
    av[idx] = 16'($urandom);
    bv[idx] = 16'($urandom);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: dut %0d in_ready %0d required 1", idx, ir[idx]);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 4000 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input int idx, input logic [15:0] a, input logic [15:0] b);
    send(idx, a, b);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, held;
    iv = '0; ordy = '1; av = '0; bv = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), int'(ir[i]), 1);
      chk($sformatf("rst_out_valid[%0d]", i), int'(ov[i]), 0);
      chk($sformatf("rst_result[%0d]", i), int'(res[i]), 0);
      chk($sformatf("rst_iters[%0d]", i), get_it(i), 0);
      chk($sformatf("rst_err[%0d]", i), int'(er[i]), 0);
    end

    // Directed pairs, including zero operands and the budget boundary.
    run(0, 12, 18);    run(1, 12, 18);    run(1, 48, 180);
    run(0, 0, 35);     run(0, 0, 0);      run(1, 35, 0);   run(1, 0, 0);
    run(0, 7, 7);      run(1, 64, 64);    run(1, 1024, 4096);
    run(2, 1, 100);    run(2, 1, 9);      run(2, 1, 10);   run(2, 3, 27);
    run(0, 65535, 1);

    // Random pairs with random consumer backpressure.
    bp_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = n % 3;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
      if (idx == 2) begin a = 16'($urandom_range(0, 24)); b = 16'($urandom_range(0, 24)); end
      run(idx, a, b);
    end
    bp_en = 1'b0;
    @(posedge clk); #1 ordy = '1;

    // Backpressure: result held, intake closed, a second request is ignored.
    @(posedge clk); #1 ordy[0] = 1'b0;
    send(0, 84, 36);
    for (int n = 0; n < 200 && !ov[0]; n++) @(negedge clk);
    chk("bp_out_valid_rise", int'(ov[0]), 1);
    held = res[0];
    @(posedge clk); #1 iv[0] = 1'b1; av[0] = 16'd5; bv[0] = 16'd10;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(ov[0]), 1);
      chk("bp_result_stable", int'(res[0]), int'(held));
      chk("bp_in_ready", int'(ir[0]), 0);
    end
    @(posedge clk); #1 iv[0] = 1'b0; ordy[0] = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("bp_no_second_result", int'(ov[0]), 0);
    chk("bp_state_idle", int'(st0), int'(IDLE));

    // Reset two cycles into a long calculation: no output may ever appear for it.
    send(0, 1, 100);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_in_ready", int'(ir[0]), 1);
    chk("rst_mid_out_valid", int'(ov[0]), 0);
    chk("rst_mid_state", int'(st0), int'(IDLE));
    repeat (150) @(negedge clk);
    chk("rst_mid_no_stale", int'(ov[0]), 0);

    // Engine is usable again after the abort.
    run(0, 21, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
